long_to_double: RTL and testbench

LONG_TO_DOUBLE -- requirements
Module: long_to_double

---
 rtl/long_to_double.sv | 148 ++++++++++++++
 tb/tb_long_to_double.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/long_to_double.sv
// ---------------------------------------------------------------------------
// LongToDouble -- converts a signed 64-bit two's-complement integer into an
// IEEE-754 binary64 value, one operand at a time, with stb/ack handshakes on
// both the input and output side.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   input_a       signed 64-bit integer operand
//   input_a_stb   upstream: input_a is valid
//   input_a_ack   block: ready to accept input_a
//   output_z      binary64 result
//   output_z_stb  block: output_z is valid
//   output_z_ack  downstream: output_z accepted
//
// The magnitude is normalised one bit per cycle, so latency depends on the
// leading-zero count of the operand. Rounding is round-to-nearest-even.
// ---------------------------------------------------------------------------
module long_to_double (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [63:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    typedef enum logic [2:0] {
        GET_A,
        CONVERT_0,
        CONVERT_1,
        CONVERT_2,
        ROUND,
        PACK,
        PUT_Z
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        r_aAck;
    logic        r_zStb;
    logic [63:0] r_a;
    logic [63:0] r_mag;
    logic [63:0] r_z;
    logic        r_sign;
    logic [10:0] r_exp;
    logic [52:0] r_mant;
    logic        r_guard;
    logic        r_round;
    logic        r_sticky;

    logic [53:0] w_mantInc;
    logic        w_roundUp;

    // Next-state logic. A transfer only happens when our registered
    // handshake output and the partner's strobe are both high.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            GET_A:     if (r_aAck && input_a_stb) w_nextState = CONVERT_0;
            CONVERT_0: w_nextState = (r_a == 64'd0) ? PUT_Z : CONVERT_1;
            CONVERT_1: if (r_mag[63]) w_nextState = CONVERT_2;
            CONVERT_2: w_nextState = ROUND;
            ROUND:     w_nextState = PACK;
            PACK:      w_nextState = PUT_Z;
            PUT_Z:     if (r_zStb && output_z_ack) w_nextState = GET_A;
            default:   w_nextState = GET_A;
        endcase
    end

    // State and handshake registers. The handshake outputs are registered
    // from the next state, so they track the state exactly during normal
    // operation, but stay low in the cycle right after a reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= GET_A;
            r_aAck  <= 1'b0;
            r_zStb  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_aAck  <= (w_nextState == GET_A);
            r_zStb  <= (w_nextState == PUT_Z);
        end
    end

    // Round-to-nearest-even: bump on guard when above half or when the
    // mantissa is odd at an exact tie.
    assign w_mantInc = {1'b0, r_mant} + 54'd1;
    assign w_roundUp = r_guard && (r_round || r_sticky || r_mant[0]);

    // Datapath. None of these registers need a reset: each one is written
    // before it is consumed on every pass through the state machine.
    always_ff @(posedge clk) begin
        case (r_state)
            GET_A: begin
                if (r_aAck && input_a_stb) begin
                    r_a <= input_a;
                end
            end
            CONVERT_0: begin
                if (r_a == 64'd0) begin
                    r_z <= 64'd0;
                end else begin
                    // Negating -2^63 wraps back to 0x8000..., which is the
                    // correct unsigned magnitude.
                    r_sign <= r_a[63];
                    r_mag  <= r_a[63] ? (~r_a + 64'd1) : r_a;
                    r_exp  <= 11'd63;
                end
            end
            CONVERT_1: begin
                if (!r_mag[63]) begin
                    r_mag <= r_mag << 1;
                    r_exp <= r_exp - 11'd1;
                end
            end
            CONVERT_2: begin
                r_mant   <= r_mag[63:11];
                r_guard  <= r_mag[10];
                r_round  <= r_mag[9];
                r_sticky <= |r_mag[8:0];
            end
            ROUND: begin
                if (w_roundUp) begin
                    if (w_mantInc[53]) begin
                        r_mant <= 53'd1 << 52;
                        r_exp  <= r_exp + 11'd1;
                    end else begin
                        r_mant <= w_mantInc[52:0];
                    end
                end
            end
            PACK: begin
                r_z <= {r_sign, r_exp + 11'd1023, r_mant[51:0]};
            end
            default: begin
            end
        endcase
    end

    assign input_a_ack  = r_aAck;
    assign output_z_stb = r_zStb;
    assign output_z     = r_z;

endmodule

// File: tb/tb_long_to_double.sv
// ---------------------------------------------------------------------------
// tb_long_to_double -- directed-vector bench for long_to_double. Expected
// results and latencies are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_long_to_double;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] aData;
    logic        aStb;
    logic        aAck;
    logic [63:0] zData;
    logic        zStb;
    logic        zAck;

    int checkCount = 0;
    int errorCount = 0;
    int cycle      = 0;
    int zTransfers = 0;

    localparam int NumVec = 12;
    logic [63:0] vecIn  [NumVec];
    logic [63:0] vecOut [NumVec];
    int          vecLat [NumVec];

    long_to_double dut (
        .clk          (clock),
        .rst          (reset),
        .input_a      (aData),
        .input_a_stb  (aStb),
        .input_a_ack  (aAck),
        .output_z     (zData),
        .output_z_stb (zStb),
        .output_z_ack (zAck)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Cycle counter and a tally of every output handshake the DUT completes
    always @(posedge clock) begin
        cycle <= cycle + 1;
        if (!reset && zStb && zAck) zTransfers <= zTransfers + 1;
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, observed, expected);
        end
    endtask

    // Push one operand through, optionally holding off output_z_ack for
    // holdCycles cycles, and report result and latency from the input
    // transfer cycle. Entered and left #1 after a rising edge.
    task automatic applyStimulus(input logic [63:0] a, input int holdCycles,
                                 output logic [63:0] z, output int latency);
        int n;
        int tCycle;
        logic stable;
        aData = a;
        aStb  = 1'b1;
        n = 0;
        while (!aAck && n < 200) begin
            @(posedge clock); #1; n++;
        end
        checkOutput("input_a_ack seen", {63'd0, aAck}, 64'd1);
        tCycle = cycle;
        @(posedge clock); #1;
        aStb  = 1'b0;
        aData = 64'd0;
        checkOutput("input_a_ack dropped", {63'd0, aAck}, 64'd0);
        n = 0;
        while (!zStb && n < 200) begin
            @(posedge clock); #1; n++;
        end
        checkOutput("output_z_stb seen", {63'd0, zStb}, 64'd1);
        checkOutput("ack/stb exclusive", {63'd0, aAck}, 64'd0);
        latency = cycle - tCycle;
        z = zData;
        stable = 1'b1;
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clock); #1;
            if (zData !== z || aAck !== 1'b0 || zStb !== 1'b1) stable = 1'b0;
        end
        if (holdCycles > 0) checkOutput("backpressure hold", {63'd0, stable}, 64'd1);
        zAck = 1'b1;
        @(posedge clock); #1;
        zAck = 1'b0;
        checkOutput("throughput ack", {63'd0, aAck}, 64'd1);
        checkOutput("output_z_stb dropped", {63'd0, zStb}, 64'd0);
    endtask

    initial begin
        logic [63:0] z;
        int          lat;
        int          savedTransfers;
        logic        quiet;

        vecIn[0]  = 64'h0000000000000000; vecOut[0]  = 64'h0000000000000000; vecLat[0]  = 2;
        vecIn[1]  = 64'h0000000000000001; vecOut[1]  = 64'h3FF0000000000000; vecLat[1]  = 69;
        vecIn[2]  = 64'hFFFFFFFFFFFFFFFF; vecOut[2]  = 64'hBFF0000000000000; vecLat[2]  = 69;
        vecIn[3]  = 64'h8000000000000000; vecOut[3]  = 64'hC3E0000000000000; vecLat[3]  = 6;
        vecIn[4]  = 64'h7FFFFFFFFFFFFFFF; vecOut[4]  = 64'h43E0000000000000; vecLat[4]  = 7;
        vecIn[5]  = 64'h0020000000000001; vecOut[5]  = 64'h4340000000000000; vecLat[5]  = 16;
        vecIn[6]  = 64'h0020000000000003; vecOut[6]  = 64'h4340000000000002; vecLat[6]  = 16;
        vecIn[7]  = 64'h0000000000000002; vecOut[7]  = 64'h4000000000000000; vecLat[7]  = 68;
        vecIn[8]  = 64'h0000000000000003; vecOut[8]  = 64'h4008000000000000; vecLat[8]  = 68;
        vecIn[9]  = 64'hFFFFFFFFFFFFFFFB; vecOut[9]  = 64'hC014000000000000; vecLat[9]  = 67;
        vecIn[10] = 64'h00000000000003E8; vecOut[10] = 64'h408F400000000000; vecLat[10] = 60;
        vecIn[11] = 64'h0000000000000000; vecOut[11] = 64'h0000000000000000; vecLat[11] = 2;

        reset = 1'b1;
        aData = 64'd0;
        aStb  = 1'b0;
        zAck  = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset input_a_ack", {63'd0, aAck}, 64'd0);
        checkOutput("reset output_z_stb", {63'd0, zStb}, 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        checkOutput("ack after reset", {63'd0, aAck}, 64'd1);

        // Directed vectors
        for (int v = 0; v < NumVec; v++) begin
            applyStimulus(vecIn[v], 0, z, lat);
            checkOutput($sformatf("value %016h", vecIn[v]), z, vecOut[v]);
            checkOutput($sformatf("latency %016h", vecIn[v]), 64'(lat), 64'(vecLat[v]));
        end

        // Backpressure for 20 cycles in PUT_Z
        applyStimulus(64'h0000000000000003, 20, z, lat);
        checkOutput("backpressure value", z, 64'h4008000000000000);

        // Reset in the middle of normalising operand 1
        aData = 64'h0000000000000001;
        aStb  = 1'b1;
        @(posedge clock); #1;
        aStb  = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        zAck = 1'b1;
        savedTransfers = zTransfers;
        reset = 1'b1;
        @(posedge clock); #1;
        checkOutput("mid reset input_a_ack", {63'd0, aAck}, 64'd0);
        checkOutput("mid reset output_z_stb", {63'd0, zStb}, 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        checkOutput("ack after mid reset", {63'd0, aAck}, 64'd1);
        quiet = 1'b1;
        repeat (80) begin
            @(posedge clock); #1;
            if (zStb !== 1'b0) quiet = 1'b0;
        end
        zAck = 1'b0;
        checkOutput("discarded operand quiet", {63'd0, quiet}, 64'd1);
        checkOutput("discarded no transfer", 64'(zTransfers), 64'(savedTransfers));

        applyStimulus(64'h0000000000000002, 0, z, lat);
        checkOutput("post reset value", z, 64'h4000000000000000);
        checkOutput("post reset latency", 64'(lat), 64'd68);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
